// File: rtl/lcd_write_controller.sv
// -----------------------------------------------------------------------------
// lcd_write_controller
//
// Write-only driver for a 16x2 HD44780-style character LCD. After reset it waits
// out the panel power-up time and plays the fixed init sequence. It then accepts
// command/character writes from the CPU over a valid/ready handshake. Every write
// goes through the same three phases:
//   SETUP : RS/DATA presented, EN low (1 cycle of address setup)
//   PULSE : EN high for EN_PULSE_CYC cycles
//   WAIT  : EN low, execution time for the panel (clear/home take longer)
// The busy flag is never read (RW is tied low), so the panel's timing is met
// purely by the cycle counts.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   req_valid  CPU has a write pending (must be held until accepted)
//   req_rs     0 = command, 1 = character data
//   req_data   byte to write
//   req_ready  high only in IDLE; a transfer happens on req_valid && req_ready
//   init_done  init sequence complete; stays high until reset
//   lcd_en     panel enable strobe
//   lcd_rs     panel register select
//   lcd_rw     panel read/write, constant 0
//   lcd_data   panel data bus
// -----------------------------------------------------------------------------
module lcd_write_controller #(
    parameter int POWERUP_CYC    = 750000,
    parameter int EN_PULSE_CYC   = 25,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    // One shared counter serves every timed state; it only ever counts from 0
    // up to (duration - 1), so it is sized for the largest duration.
    localparam int MAX_AB  = (POWERUP_CYC > EN_PULSE_CYC) ? POWERUP_CYC : EN_PULSE_CYC;
    localparam int MAX_CD  = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PU_LAST    = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

    localparam logic [2:0] ST_POWERUP = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_PULSE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_IDLE    = 3'd4;

    // Index of the final init byte; reaching the end of its WAIT finishes init.
    localparam logic [2:0] INIT_LAST_IDX = 3'd5;

    // Function set 8-bit/2-line (three times, as the panel's reset-by-instruction
    // procedure requires), display on / cursor off, clear, entry mode increment.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h38;
            3'd1:    b = 8'h38;
            3'd2:    b = 8'h38;
            3'd3:    b = 8'h0C;
            3'd4:    b = 8'h01;
            3'd5:    b = 8'h06;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [2:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       init_idx_q,  init_idx_d;
    logic             init_done_q, init_done_d;
    logic             lcd_en_q,    lcd_en_d;
    logic             lcd_rs_q,    lcd_rs_d;
    logic [7:0]       lcd_data_q,  lcd_data_d;

    // Clear (0x01) and return-home (0x02) are the only slow instructions.
    logic             slow_cmd;
    logic [CNT_W-1:0] wait_last;

    assign slow_cmd  = !lcd_rs_q && ((lcd_data_q == 8'h01) || (lcd_data_q == 8'h02));
    assign wait_last = slow_cmd ? CLEAR_LAST : CMD_LAST;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        lcd_en_d    = 1'b0;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;

        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == PU_LAST) begin
                    state_d    = ST_SETUP;
                    cnt_d      = '0;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_byte(3'd0);
                end
            end

            ST_SETUP: begin
                // EN is registered, so raising it here makes it high for the
                // whole first PULSE cycle.
                state_d  = ST_PULSE;
                cnt_d    = '0;
                lcd_en_d = 1'b1;
            end

            ST_PULSE: begin
                lcd_en_d = 1'b1;
                if (cnt_q == EN_LAST) begin
                    state_d  = ST_WAIT;
                    cnt_d    = '0;
                    lcd_en_d = 1'b0;
                end
            end

            ST_WAIT: begin
                // RS/DATA are left untouched here, which gives the hold time
                // after the falling edge of EN for free.
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (init_idx_q < INIT_LAST_IDX) begin
                        init_idx_d = init_idx_q + 3'd1;
                        lcd_rs_d   = 1'b0;
                        lcd_data_d = init_byte(init_idx_q + 3'd1);
                        state_d    = ST_SETUP;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    lcd_rs_d   = req_rs;
                    lcd_data_d = req_data;
                    state_d    = ST_SETUP;
                end
            end

            default: begin
                // Unreachable encodings restart the panel from scratch.
                state_d     = ST_POWERUP;
                cnt_d       = '0;
                init_idx_d  = 3'd0;
                init_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_POWERUP;
            cnt_q       <= '0;
            init_idx_q  <= 3'd0;
            init_done_q <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            lcd_en_q    <= lcd_en_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign init_done = init_done_q;
    assign lcd_en    = lcd_en_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = lcd_data_q;

endmodule

// File: doc/lcd_write_controller.md
Name: lcd_write_controller

Overview:
- Downstream stage of the CPU core; owns the 16x2 HD44780-style character LCD on the board.
- Accepts command and character write requests from the CPU over a valid/ready handshake.
- Runs the mandatory power-up init sequence.
- Drives EN/RS/RW/data to the panel with the required setup, pulse-width and execution-wait timing, counted in clk cycles.

Parameters:
- POWERUP_CYC, 750000, cycles held idle after reset before the first init write (15 ms @ 50 MHz).
- EN_PULSE_CYC, 25, cycles lcd_en is held high per write.
- CMD_WAIT_CYC, 2000, cycles waited after EN falls for normal commands and data (40 us).
- CLEAR_WAIT_CYC, 82000, cycles waited after EN falls for clear (0x01) and home (0x02) commands (1.64 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU has a write pending.
- req_rs  in  1  0 = command, 1 = character data.
- req_data  in  8  byte to write.
- req_ready  out  1  controller can accept a request this cycle.
- init_done  out  1  init sequence complete; stays high until reset.
- lcd_en  out  1  panel enable strobe.
- lcd_rs  out  1  panel register select.
- lcd_rw  out  1  panel read/write; tied 0 (write-only).
- lcd_data  out  8  panel data bus.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs low (req_ready=0, init_done=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00). State = POWERUP, counter = 0, init index = 0.
- States: POWERUP, SETUP, PULSE, WAIT, IDLE.
- POWERUP: count POWERUP_CYC cycles. Then load init byte 0 with rs=0 and go to SETUP.
- Init sequence, in order: 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06. All are rs=0. Each goes through SETUP, PULSE, WAIT.
- SETUP (exactly 1 cycle): lcd_rs and lcd_data are driven with the latched byte, lcd_en=0. Next state PULSE.
- PULSE: lcd_en=1 for exactly EN_PULSE_CYC cycles. rs/data stay stable. Then lcd_en=0 and go to WAIT.
- WAIT: lcd_en=0. rs/data hold their value through the first cycle of WAIT (hold time), and may hold longer.
  - Duration is CLEAR_WAIT_CYC if the latched rs=0 and data is 8'h01 or 8'h02; otherwise CMD_WAIT_CYC.
  - At the end of WAIT during init: if the index is below 5, increment it, load the next byte and go to SETUP.
  - At the end of the last init byte: set init_done=1 and go to IDLE.
  - At the end of WAIT after a CPU write: go to IDLE.
- IDLE: req_ready=1, and req_ready is high in no other state.
- Handshake: a transfer occurs on a cycle where req_valid && req_ready.
  - req_rs and req_data are latched, and the state goes to SETUP next cycle.
  - req_ready is 0 from the cycle after acceptance until the controller returns to IDLE.
- Requests before init_done are not accepted because req_ready=0. The CPU must hold req_valid; nothing is dropped.
- Back-to-back: if req_valid is held, the next request is accepted on the first IDLE cycle. Minimum spacing between acceptances is 1 + EN_PULSE_CYC + CMD_WAIT_CYC + 1 cycles.
- Counters are wide enough for the largest parameter (20 bits at defaults). They are cleared on each state entry and must not wrap.
- Reset mid-operation, including mid-PULSE: lcd_en drops immediately (asynchronous). The full POWERUP and init sequence reruns, and init_done returns to 0.
- lcd_rw is constant 0 and the controller never polls the busy flag. The panel's timing is met purely by the cycle counts.

Test Plan:
- Small parameters (POWERUP_CYC=10, EN_PULSE_CYC=3, CMD_WAIT_CYC=5, CLEAR_WAIT_CYC=12), reset released, req_valid=0 -> no EN edge for 10 cycles. Then exactly six EN pulses carrying 38,38,38,0C,01,06 with rs=0, each 3 cycles high. The gap after 01 is 12 cycles, the others 5. Then init_done=1 and req_ready=1.
- req_valid=1, rs=1, data=8'h41 held from time 0 -> not accepted until init_done. Then one pulse with rs=1, data=41. req_ready is low for 1+3+5 cycles and returns high.
- Two queued requests, 0x48 then 0x49, with req_valid held -> EN rising edges exactly 10 cycles apart. Data is stable for the whole high period and for one cycle after the falling edge.
- Command rs=0, data=8'h02 after init -> post-pulse wait is 12 cycles. Command rs=0, data=8'h80 -> post-pulse wait is 5 cycles.
- Assert rst during the second cycle of a data PULSE -> lcd_en=0 in the same cycle. After release, init_done=0 and the full init sequence repeats.
- Throughout all runs -> lcd_rw is never 1, and req_ready is never high when init_done=0.
